// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared constants for the sprite engine and its motion sub-block:
//   SCR_W, SCR_H   default visible screen size
//   SPR_LAT        pixel pipeline latency from xx/yy to o_sprite_on/o_pixel
//   MODE_*         i_mode encodings
//   DIR_*          bit indices into the {up, down, left, right} direction bus
//   vel_e          per-axis velocity sign used in bounce mode
package sprite_pkg;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int SPR_LAT = 3;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic {
    VEL_POS = 1'b0,
    VEL_NEG = 1'b1
  } vel_e;

endpackage

// File: rtl/sprite_motion.sv
// sprite_motion
// One axis of sprite movement. On each frame tick the position either
// follows the direction inputs (manual, clamped to 0..LIMIT) or bounces
// between 0 and LIMIT, flipping its velocity sign when it hits an edge.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_tick        one-cycle frame tick; the only cycle the position moves
//   i_mode        MODE_MANUAL / MODE_BOUNCE
//   i_dec, i_inc  manual-mode move towards 0 / towards LIMIT
//   o_pos         current position on this axis
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int LIMIT = 606,
  parameter int START = 300,
  parameter int STEP  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_dec,
  input  logic       i_inc,
  output logic [9:0] o_pos
);

  logic [9:0]  pos_q, pos_d;
  vel_e        vel_q, vel_d;
  logic [10:0] up_w;
  logic [9:0]  dn_w;
  logic        dn_under;

  // The upward candidate is kept 11 bits wide so LIMIT checks near the top
  // of the 10-bit range cannot wrap; the downward one is guarded by dn_under.
  always_comb begin
    up_w     = {1'b0, pos_q} + 11'(STEP);
    dn_w     = pos_q - 10'(STEP);
    dn_under = ({1'b0, pos_q} < 11'(STEP));
    pos_d    = pos_q;
    vel_d    = vel_q;
    if (i_tick) begin
      if (i_mode == MODE_BOUNCE) begin
        if (vel_q == VEL_POS) begin
          if (up_w > 11'(LIMIT)) begin
            pos_d = 10'(LIMIT);
            vel_d = VEL_NEG;
          end else begin
            pos_d = up_w[9:0];
          end
        end else begin
          if (dn_under) begin
            pos_d = '0;
            vel_d = VEL_POS;
          end else begin
            pos_d = dn_w;
          end
        end
      end else begin
        // Opposing inputs cancel out, leaving the axis still.
        if (i_inc && !i_dec) begin
          pos_d = (up_w > 11'(LIMIT)) ? 10'(LIMIT) : up_w[9:0];
        end else if (i_dec && !i_inc) begin
          pos_d = dn_under ? '0 : dn_w;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_q <= 10'(START);
      vel_q <= VEL_POS;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign o_pos = pos_q;

endmodule

// File: rtl/sprite_engine.sv
// sprite_engine
// Renders one SPR_W x SPR_H sprite from an external synchronous ROM at a
// position that moves once per frame (manual or bounce mode).
// Ports:
//   i_clk, i_rst      pixel clock, async active-high reset
//   xx, yy, aactive   scan position and visible-area flag
//   i_frame_tick      start-of-vblank pulse; position updates only here
//   i_mode, i_dir     motion mode and {up, down, left, right} buttons
//   i_rom_data        ROM pixel, one cycle after o_rom_addr
//   o_rom_addr        sprite ROM address
//   o_sprite_on       opaque sprite pixel, 3 cycles after xx/yy
//   o_pixel           pixel index, 0 when o_sprite_on is low
//   o_pos_x, o_pos_y  sprite top-left corner
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int               SPR_W   = 34,
  parameter int               SPR_H   = 27,
  parameter int               ADDR_W  = 10,
  parameter int               DATA_W  = 8,
  parameter int               SCR_W   = sprite_pkg::SCR_W,
  parameter int               SCR_H   = sprite_pkg::SCR_H,
  parameter int               START_X = 300,
  parameter int               START_Y = 100,
  parameter int               STEP    = 2,
  parameter logic [DATA_W-1:0] TRANSP = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        xx,
  input  logic [9:0]        yy,
  input  logic              aactive,
  input  logic              i_frame_tick,
  input  logic              i_mode,
  input  logic [3:0]        i_dir,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_sprite_on,
  output logic [DATA_W-1:0] o_pixel,
  output logic [9:0]        o_pos_x,
  output logic [9:0]        o_pos_y
);

  logic [9:0]        pos_x, pos_y;
  logic [10:0]       x11, y11, px11, py11;
  logic [9:0]        dx, dy;
  logic              in_box;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              v1_q, v2_q;
  logic              sprite_on_q, sprite_on_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;

  sprite_motion #(
    .LIMIT(SCR_W - SPR_W),
    .START(START_X),
    .STEP (STEP)
  ) u_motion_x (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_tick(i_frame_tick),
    .i_mode(i_mode),
    .i_dec (i_dir[DIR_LEFT]),
    .i_inc (i_dir[DIR_RIGHT]),
    .o_pos (pos_x)
  );

  sprite_motion #(
    .LIMIT(SCR_H - SPR_H),
    .START(START_Y),
    .STEP (STEP)
  ) u_motion_y (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_tick(i_frame_tick),
    .i_mode(i_mode),
    .i_dec (i_dir[DIR_UP]),
    .i_inc (i_dir[DIR_DOWN]),
    .o_pos (pos_y)
  );

  // Box test in 11 bits so pos + size at the right/bottom edge cannot wrap.
  // The offsets dx/dy are only meaningful inside the box, which is the only
  // time the address register loads.
  always_comb begin
    x11        = {1'b0, xx};
    y11        = {1'b0, yy};
    px11       = {1'b0, pos_x};
    py11       = {1'b0, pos_y};
    in_box     = aactive &&
                 (x11 >= px11) && (x11 < px11 + 11'(SPR_W)) &&
                 (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
    dx         = xx - pos_x;
    dy         = yy - pos_y;
    rom_addr_d = rom_addr_q;
    if (in_box) begin
      rom_addr_d = ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W);
    end
  end

  always_comb begin
    sprite_on_d = v2_q && (i_rom_data != TRANSP);
    pixel_d     = sprite_on_d ? i_rom_data : '0;
  end

  // C1 address/valid, C2 ROM read delay, C3 colour-key and output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      sprite_on_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      v1_q        <= in_box;
      v2_q        <= v1_q;
      sprite_on_q <= sprite_on_d;
      pixel_q     <= pixel_d;
    end
  end

  assign o_rom_addr  = rom_addr_q;
  assign o_sprite_on = sprite_on_q;
  assign o_pixel     = pixel_q;
  assign o_pos_x     = pos_x;
  assign o_pos_y     = pos_y;

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine
// Drives sprite_engine with directed and randomized scans/ticks and checks
// it against a behavioural model: a pixel queue of depth SPR_LAT and a
// plain-integer position/velocity model per axis.
module tb_sprite_engine;
  import sprite_pkg::*;

  localparam int SPR_W = 34;
  localparam int SPR_H = 27;
  localparam int STEP  = 2;
  localparam int LIMX  = SCR_W - SPR_W;
  localparam int LIMY  = SCR_H - SPR_H;
  localparam logic [7:0] TRANSP = 8'h00;
  localparam logic [3:0] D_NONE = 4'b0000;
  localparam logic [3:0] D_UP = 4'b1000;
  localparam logic [3:0] D_DOWN = 4'b0100;
  localparam logic [3:0] D_LEFT = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;

  logic       clk;
  logic       rst;
  logic [9:0] xx, yy;
  logic       aactive, tick, mode;
  logic [3:0] dir;
  logic [7:0] rom_data;
  logic [9:0] rom_addr;
  logic       sprite_on;
  logic [7:0] pixel;
  logic [9:0] pos_x, pos_y;

  logic [7:0] rom [0:1023];

  int errors = 0;
  int checks = 0;

  int   mx, my;
  bit   mvxn, mvyn;
  bit   qOn[$];
  logic [7:0] qPix[$];
  int   expAddr;
  bit   expOn;
  logic [7:0] expPix;

  sprite_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .xx          (xx),
    .yy          (yy),
    .aactive     (aactive),
    .i_frame_tick(tick),
    .i_mode      (mode),
    .i_dir       (dir),
    .i_rom_data  (rom_data),
    .o_rom_addr  (rom_addr),
    .o_sprite_on (sprite_on),
    .o_pixel     (pixel),
    .o_pos_x     (pos_x),
    .o_pos_y     (pos_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic model_reset();
    mx = 300;
    my = 100;
    mvxn = 1'b0;
    mvyn = 1'b0;
    expAddr = 0;
    qOn.delete();
    qPix.delete();
    for (int i = 0; i < SPR_LAT - 1; i++) begin
      qOn.push_back(1'b0);
      qPix.push_back(8'h00);
    end
  endtask

  function automatic int axis_update(input int p, input int lim, input bit bounce,
                                     input bit dec, input bit inc, inout bit neg);
    int n;
    if (bounce) begin
      n = neg ? p - STEP : p + STEP;
      if (n > lim) begin
        neg = 1'b1;
        return lim;
      end
      if (n < 0) begin
        neg = 1'b0;
        return 0;
      end
      return n;
    end
    n = p + (inc ? STEP : 0) - (dec ? STEP : 0);
    if (n > lim) return lim;
    if (n < 0) return 0;
    return n;
  endfunction

  // One clock of stimulus; leaves the model's expectations for the outputs
  // visible #1 after this edge in expOn/expPix/expAddr/mx/my.
  task automatic step(input int x, input int y, input bit act, input bit tk,
                      input bit md, input logic [3:0] d);
    bit inb;
    int a;
    xx = 10'(x);
    yy = 10'(y);
    aactive = act;
    tick = tk;
    mode = md;
    dir = d;
    inb = act && x >= mx && x < mx + SPR_W && y >= my && y < my + SPR_H;
    if (inb) begin
      a = (x - mx) + (y - my) * SPR_W;
      expAddr = a;
      qOn.push_back(rom[a] != TRANSP);
      qPix.push_back(rom[a] != TRANSP ? rom[a] : 8'h00);
    end else begin
      qOn.push_back(1'b0);
      qPix.push_back(8'h00);
    end
    if (tk) begin
      mx = axis_update(mx, LIMX, md, d[1], d[0], mvxn);
      my = axis_update(my, LIMY, md, d[3], d[2], mvyn);
    end
    @(posedge clk);
    #1;
    tick = 1'b0;
    expOn = qOn.pop_front();
    expPix = qPix.pop_front();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (sprite_on !== 1'b0 || pixel !== 8'h00 || rom_addr !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got on=%0b pix=%h addr=%0d, want 0/00/0", sprite_on, pixel, rom_addr);
    end
    checks++;
    if (pos_x !== 10'd300 || pos_y !== 10'd100) begin
      errors++;
      $display("[TB] FAIL reset_pos: got (%0d,%0d), want (300,100)", pos_x, pos_y);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_pixel();
    step(300, 100, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (rom_addr !== 10'd0) begin
      errors++;
      $display("[TB] FAIL first_addr: got %0d, want 0", rom_addr);
    end
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (sprite_on !== 1'b1 || pixel !== 8'h1F || expOn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_pixel: got on=%0b pix=%h, want 1/1f", sprite_on, pixel);
    end
  endtask

  task automatic test_transparent();
    step(333, 126, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (rom_addr !== 10'd917) begin
      errors++;
      $display("[TB] FAIL transp_addr: got %0d, want 917", rom_addr);
    end
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (sprite_on !== 1'b0 || pixel !== 8'h00) begin
      errors++;
      $display("[TB] FAIL transp_pixel: got on=%0b pix=%h, want 0/00", sprite_on, pixel);
    end
  endtask

  task automatic test_no_prefetch();
    step(299, 100, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    step(334, 100, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (rom_addr !== 10'd917) begin
      errors++;
      $display("[TB] FAIL edge_addr_hold: got %0d, want 917", rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sprite_on !== 1'b0 || sprite_on !== expOn) begin
        errors++;
        $display("[TB] FAIL edge_column: cycle %0d got on=%0b, want 0", i, sprite_on);
      end
      step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    end
  endtask

  task automatic test_random_scan();
    int x, y;
    for (int i = 0; i < 200; i++) begin
      x = mx - 3 + int'($urandom_range(0, SPR_W + 5));
      y = my - 3 + int'($urandom_range(0, SPR_H + 5));
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      step(x, y, ($urandom_range(0, 5) != 0), 1'b0, MODE_MANUAL, D_NONE);
      checks++;
      if (sprite_on !== expOn || pixel !== expPix || rom_addr !== 10'(expAddr)) begin
        errors++;
        $display("[TB] FAIL rand_scan: i=%0d got on=%0b pix=%h addr=%0d, want %0b/%h/%0d",
                 i, sprite_on, pixel, rom_addr, expOn, expPix, expAddr);
      end
    end
  endtask

  task automatic test_tick_coincident();
    step(310, 105, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    step(300, 100, 1'b1, 1'b1, MODE_MANUAL, D_RIGHT);
    checks++;
    if (rom_addr !== 10'd0 || pos_x !== 10'd302) begin
      errors++;
      $display("[TB] FAIL tick_coincident: got addr=%0d pos_x=%0d, want 0/302", rom_addr, pos_x);
    end
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
    checks++;
    if (sprite_on !== 1'b1 || pixel !== 8'h1F) begin
      errors++;
      $display("[TB] FAIL tick_old_pos_pixel: got on=%0b pix=%h, want 1/1f", sprite_on, pixel);
    end
  endtask

  task automatic test_manual_clamp();
    do_reset();
    for (int i = 0; i < 150; i++) step(0, 0, 1'b0, 1'b1, MODE_MANUAL, D_LEFT);
    checks++;
    if (pos_x !== 10'd0) begin
      errors++;
      $display("[TB] FAIL left_reach_zero: got %0d, want 0", pos_x);
    end
    step(0, 0, 1'b0, 1'b1, MODE_MANUAL, D_LEFT);
    checks++;
    if (pos_x !== 10'd0) begin
      errors++;
      $display("[TB] FAIL left_clamp: got %0d, want 0", pos_x);
    end
    step(0, 0, 1'b0, 1'b1, MODE_MANUAL, D_LEFT | D_RIGHT | D_UP | D_DOWN);
    checks++;
    if (pos_x !== 10'd0 || pos_y !== 10'd100) begin
      errors++;
      $display("[TB] FAIL opposing_dirs: got (%0d,%0d), want (0,100)", pos_x, pos_y);
    end
    for (int i = 0; i < 230; i++) step(0, 0, 1'b0, 1'b1, MODE_MANUAL, D_DOWN);
    checks++;
    if (pos_y !== 10'(LIMY) || 453 !== my) begin
      errors++;
      $display("[TB] FAIL down_clamp: got %0d, want 453", pos_y);
    end
    step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_UP);
    checks++;
    if (pos_y !== 10'd453) begin
      errors++;
      $display("[TB] FAIL dir_without_tick: got %0d, want 453", pos_y);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 152; i++) step(0, 0, 1'b0, 1'b1, MODE_MANUAL, D_RIGHT);
    checks++;
    if (pos_x !== 10'd604) begin
      errors++;
      $display("[TB] FAIL bounce_setup: got %0d, want 604", pos_x);
    end
    step(0, 0, 1'b0, 1'b1, MODE_BOUNCE, D_LEFT);
    checks++;
    if (pos_x !== 10'd606 || pos_y !== 10'(my)) begin
      errors++;
      $display("[TB] FAIL bounce_reach_limit: got (%0d,%0d), want (606,%0d)", pos_x, pos_y, my);
    end
    step(0, 0, 1'b0, 1'b1, MODE_BOUNCE, D_NONE);
    checks++;
    if (pos_x !== 10'd606) begin
      errors++;
      $display("[TB] FAIL bounce_flip_hold: got %0d, want 606", pos_x);
    end
    step(0, 0, 1'b0, 1'b1, MODE_BOUNCE, D_NONE);
    checks++;
    if (pos_x !== 10'd604) begin
      errors++;
      $display("[TB] FAIL bounce_reverse: got %0d, want 604", pos_x);
    end
  endtask

  task automatic test_random_motion();
    for (int i = 0; i < 400; i++) begin
      step(0, 0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
      checks++;
      if (pos_x !== 10'(mx) || pos_y !== 10'(my)) begin
        errors++;
        $display("[TB] FAIL rand_motion: i=%0d got (%0d,%0d), want (%0d,%0d)", i, pos_x, pos_y, mx, my);
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    step(300, 100, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    step(301, 100, 1'b1, 1'b0, MODE_MANUAL, D_NONE);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sprite_on !== 1'b0 || pixel !== 8'h00 || rom_addr !== 10'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got on=%0b pix=%h addr=%0d, want 0/00/0", sprite_on, pixel, rom_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (pos_x !== 10'd300 || pos_y !== 10'd100) begin
      errors++;
      $display("[TB] FAIL midreset_pos: got (%0d,%0d), want (300,100)", pos_x, pos_y);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1'b0, 1'b0, MODE_MANUAL, D_NONE);
      checks++;
      if (sprite_on !== 1'b0 || pixel !== 8'h00) begin
        errors++;
        $display("[TB] FAIL midreset_flush: cycle %0d got on=%0b pix=%h, want 0/00", i, sprite_on, pixel);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    rom[0]   = 8'h1F;
    rom[917] = TRANSP;
    rst = 1'b1;
    xx = '0;
    yy = '0;
    aactive = 1'b0;
    tick = 1'b0;
    mode = MODE_MANUAL;
    dir = D_NONE;
    model_reset();
    @(posedge clk);
    #1;
    $display("[TB] starting sprite_engine tests");
    test_reset();
    test_first_pixel();
    test_transparent();
    test_no_prefetch();
    test_random_scan();
    test_tick_coincident();
    test_manual_clamp();
    test_bounce();
    test_random_motion();
    test_random_scan();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised successor to the fixed-position sprite block. It renders one W×H sprite from an external synchronous sprite ROM at a movable position.
- Position updates once per frame, either from player direction inputs (manual mode) or by autonomous edge-bouncing (bounce mode). A transparency colour key masks out background pixels.
- Sits between the VGA timing generator (xx, yy, aactive, frame tick) and the pixel mux/colour palette.

Parameters:
- SPR_W, 34, sprite width in pixels
- SPR_H, 27, sprite height in pixels
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- DATA_W, 8, ROM pixel/palette index width
- SCR_W, 640, visible screen width
- SCR_H, 480, visible screen height
- START_X, 300, X position after reset
- START_Y, 100, Y position after reset
- STEP, 2, pixels moved per frame tick on each axis
- TRANSP, 8'h00, colour key treated as transparent

Ports:
- i_clk  in  1  pixel-domain clock
- i_rst  in  1  asynchronous, active-high reset
- xx  in  10  current scan X
- yy  in  10  current scan Y
- aactive  in  1  high during visible area
- i_frame_tick  in  1  one-cycle pulse at start of vertical blanking
- i_mode  in  1  0 = manual, 1 = bounce
- i_dir  in  4  {up, down, left, right}, sampled only on i_frame_tick
- i_rom_data  in  DATA_W  ROM output, valid 1 cycle after o_rom_addr
- o_rom_addr  out  ADDR_W  sprite ROM address
- o_sprite_on  out  1  opaque sprite pixel at this output cycle
- o_pixel  out  DATA_W  pixel index; 0 when o_sprite_on = 0
- o_pos_x  out  10  current sprite X (top-left)
- o_pos_y  out  10  current sprite Y (top-left)

Behaviour:
- Reset (async, i_rst = 1):
  - pos = (START_X, START_Y); velocity = (+STEP, +STEP).
  - o_rom_addr, o_sprite_on, o_pixel and all pipeline valid bits = 0.
  - Reset mid-frame kills in-flight pixels: no partial sprite is emitted after release.
- In-box test:
  - in_box = aactive && pos_x <= xx < pos_x+SPR_W && pos_y <= yy < pos_y+SPR_H.
  - Compare in 11 bits so pos = 0 and right/bottom edges do not wrap. There is no off-by-one pre-fetch column.
- Pipeline, fixed 3-cycle latency from xx/yy to o_sprite_on/o_pixel:
  - C1: register o_rom_addr = (xx-pos_x) + (yy-pos_y)*SPR_W (constant multiply, ADDR_W truncation); v1 = in_box.
    - When not in box, o_rom_addr holds its last value.
  - C2: ROM returns i_rom_data; v2 = v1.
  - C3: o_sprite_on = v2 && (i_rom_data != TRANSP); o_pixel = o_sprite_on ? i_rom_data : 0.
  - Downstream must delay its own xx/yy-derived signals by 3 to align.
- Position update, only on the i_frame_tick cycle, so there is no mid-frame tearing:
  - Manual mode:
    - up → y -= STEP; down → y += STEP; left → x -= STEP; right → x += STEP.
    - Opposing bits both set → no motion on that axis.
    - Clamp results to 0..SCR_W-SPR_W and 0..SCR_H-SPR_H; no wrap-around.
  - Bounce mode:
    - Per axis, next = pos ± STEP by velocity sign.
    - If next would leave the range, pos = the limit reached and that axis' velocity sign flips in the same cycle.
    - Otherwise pos = next.
    - i_dir is ignored.
  - Mode switch takes effect at the next tick. Velocity signs are retained across mode switches.
- The updated pos is visible on o_pos_x/o_pos_y the cycle after the tick and is used by the in-box test from then on.
- A frame tick coincident with an in-box pixel is legal: that pixel uses the old pos.

Decomposition:
- Shared package/header `sprite_pkg`:
  - screen constants SCR_W, SCR_H
  - the pipeline latency constant SPR_LAT = 3
  - mode encodings MODE_MANUAL = 0, MODE_BOUNCE = 1
  - i_dir bit indices
- One sub-module `sprite_motion`: the frame-tick position/velocity update with clamp and bounce logic, reused per axis or for both axes. It has no rendering knowledge.
- Render pipeline stays in sprite_engine. The ROM stays external (per-sprite ROM instance).

Test Plan:
- Reset then scan pixel (300,100) with aactive = 1:
  - o_rom_addr = 0 one cycle later.
  - o_sprite_on = 1 three cycles later when ROM[0] = 8'h1F; o_pixel = 8'h1F.
- Scan (333,126) with ROM[917] = TRANSP:
  - o_rom_addr = 917; o_sprite_on = 0; o_pixel = 0.
- Scan (299,100) and (334,100):
  - o_sprite_on stays 0, confirming there is no pre-fetch column.
- Manual mode, pos_x = 1, i_dir = left, tick:
  - pos_x = 0.
  - Second tick → pos_x stays 0.
  - i_dir = left|right → pos unchanged.
- Bounce mode, pos_x = 605, vx = +2, tick:
  - pos_x = 606 (= 640-34) and vx becomes −2.
  - Next tick → pos_x = 604.
- Assert i_rst for one cycle mid-sprite:
  - Outputs go to 0 immediately; pos returns to (300,100).
  - No o_sprite_on pulses in the 3 cycles after release unless a new in-box pixel is scanned.
